// File: rtl/seq_pkg.sv
// ============================================================================
// Module   : seq_pkg
// Purpose  : Stage encodings shared by the sequencer, the CPU top and benches.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_IF   = 3'd0,
    ST_RR   = 3'd1,
    ST_EX   = 3'd2,
    ST_MA   = 3'd3,
    ST_RW   = 3'd4,
    ST_HALT = 3'd5
  } stage_e;

endpackage

`default_nettype wire

// File: rtl/seq_perf_counter.sv
// ============================================================================
// Module   : seq_perf_counter
// Purpose  : Free-running wrap-around event counter with synchronous clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/stage_sequencer.sv
// ============================================================================
// Module   : stage_sequencer
// Purpose  : Multi-cycle IF/RR/EX/MA/RW stage FSM and PC register with
//            variable-latency memory handshakes and sticky HALT.
// Options  : SEQ_PERF_CNT_EN enables the cycle / retired-instruction counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_sequencer
  import seq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h7FFC,
  parameter bit              SKIP_MA  = 1'b1,
  parameter int              CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    npc,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_halt,
  input  logic               reg_we_dec,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic [XLEN-1:0]    pc,
  output logic [STAGE_W-1:0] stage,
  output logic               imem_req,
  output logic               dec_en,
  output logic               alu_en,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               reg_we,
  output logic               retired,
  output logic               halted,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  stage_e          r_state;
  stage_e          w_next_state;
  logic [XLEN-1:0] r_pc;

  logic w_is_mem;
  logic w_imem_req, w_dec_en, w_alu_en, w_dmem_req, w_dmem_we;
  logic w_reg_we, w_retired, w_halted;
  logic w_unused_npc;

  assign w_is_mem     = is_load | is_store;
  assign w_unused_npc = ^npc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IF;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RW) begin
        r_pc <= {npc[XLEN-1:2], 2'b00};
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_dec_en     = 1'b0;
    w_alu_en     = 1'b0;
    w_dmem_req   = 1'b0;
    w_dmem_we    = 1'b0;
    w_reg_we     = 1'b0;
    w_retired    = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      ST_IF: begin
        w_imem_req = 1'b1;
        if (imem_ready) w_next_state = ST_RR;
      end
      ST_RR: begin
        w_dec_en     = 1'b1;
        w_next_state = ST_EX;
      end
      ST_EX: begin
        w_alu_en = 1'b1;
        // Halt wins over a simultaneous load/store decode.
        if (is_halt)           w_next_state = ST_HALT;
        else if (w_is_mem)     w_next_state = ST_MA;
        else if (SKIP_MA)      w_next_state = ST_RW;
        else                   w_next_state = ST_MA;
      end
      ST_MA: begin
        if (w_is_mem) begin
          w_dmem_req = 1'b1;
          w_dmem_we  = is_store;
          if (dmem_ready) w_next_state = ST_RW;
        end else begin
          w_next_state = ST_RW;
        end
      end
      ST_RW: begin
        w_reg_we     = reg_we_dec;
        w_retired    = 1'b1;
        w_next_state = ST_IF;
      end
      ST_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_next_state = ST_IF;
      end
    endcase
  end

  // Decoded outputs drop in the very cycle rst is asserted.
  assign imem_req = w_imem_req & ~rst;
  assign dec_en   = w_dec_en   & ~rst;
  assign alu_en   = w_alu_en   & ~rst;
  assign dmem_req = w_dmem_req & ~rst;
  assign dmem_we  = w_dmem_we  & ~rst;
  assign reg_we   = w_reg_we   & ~rst;
  assign retired  = w_retired  & ~rst;
  assign halted   = w_halted   & ~rst;

  assign pc    = r_pc;
  assign stage = r_state;

`ifdef SEQ_PERF_CNT_EN
  seq_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (r_state != ST_HALT),
    .count (cycle_cnt)
  );

  seq_perf_counter #(.CNT_W(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (retired),
    .count (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire
